seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/seg7_glyph_decode.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: glyph constants, FSM states
// and the anode one-cold index helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Returns {legal, idx}: legal when exactly one bit of the active-low bus is 0.
  function automatic logic [3:0] onehot0_index(input logic [7:0] an_n);
    logic [2:0] idx;
    int         zeros;
    idx   = '0;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!an_n[i]) begin
        zeros++;
        idx = 3'(i);
      end
    end
    return {(zeros == 1), idx};
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Inverse of the hex-to-7-segment encoder: active-low segment pattern to nibble.
// Unknown patterns (including blank) decode to 0 with ok cleared.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       ok
);

  always_comb begin
    nibble = 4'h0;
    ok     = 1'b1;
    case (seg_n)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: ok     = 1'b0;
      default:   ok     = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low segment/anode bus, recovers each digit once its
// pattern has been stable long enough, and emits complete frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    bus_err
);

  localparam int              SW      = NUM_DIGITS + 7;
  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  logic [SW-1:0]           smp_q, smp_prev_q;
  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              cap_idx_q;
  logic [3:0]              cap_nib_q;
  logic                    cap_ok_q;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d;
  logic [NUM_DIGITS-1:0]   stg_ok_q, stg_ok_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   digit_ok_q, digit_ok_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    bus_err_q, bus_err_d;

  logic [7:0]              an_pad;
  logic [3:0]              an_info;
  logic                    legal_cur, multi_cur, same;
  logic [3:0]              dec_nib;
  logic                    dec_ok;
  logic                    capture, bus_err_set, frame_done;
  logic [NUM_DIGITS-1:0]   wr_en;

  always_comb begin
    an_pad                 = '1;
    an_pad[NUM_DIGITS-1:0] = smp_q[SW-1:7];
  end

  assign an_info   = onehot0_index(an_pad);
  assign legal_cur = an_info[3];
  assign multi_cur = !legal_cur && !(&smp_q[SW-1:7]);
  assign same      = (smp_q == smp_prev_q);

  seg7_glyph_decode u_decode (
    .seg_n  (smp_q[6:0]),
    .nibble (dec_nib),
    .ok     (dec_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q         <= '0;
      smp_prev_q    <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      cap_idx_q     <= '0;
      cap_nib_q     <= '0;
      cap_ok_q      <= 1'b0;
      mask_q        <= '0;
      stg_val_q     <= '0;
      stg_ok_q      <= '0;
      value_q       <= '0;
      digit_ok_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      smp_q         <= {an_n, seg_n};
      smp_prev_q    <= smp_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      // Decoded one cycle behind smp_q, so in CAPTURE it holds the stable pattern.
      cap_idx_q     <= an_info[2:0];
      cap_nib_q     <= dec_nib;
      cap_ok_q      <= dec_ok;
      mask_q        <= mask_d;
      stg_val_q     <= stg_val_d;
      stg_ok_q      <= stg_ok_d;
      value_q       <= value_d;
      digit_ok_q    <= digit_ok_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      bus_err_q     <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (legal_cur) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (!legal_cur) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d = CW'(1);
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = same ? HOLD : IDLE;
      end
      HOLD: begin
        if (!same) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture     = (state_q == CAPTURE);
    bus_err_set = ((state_q == SETTLE) || (state_q == HOLD)) && multi_cur;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_stage
    assign wr_en[gi]              = capture && (cap_idx_q == 3'(gi));
    assign stg_val_d[4*gi +: 4]   = wr_en[gi] ? cap_nib_q : stg_val_q[4*gi +: 4];
    assign stg_ok_d[gi]           = wr_en[gi] ? cap_ok_q  : stg_ok_q[gi];
  end

  always_comb begin
    frame_done    = &mask_q;
    mask_d        = (frame_done ? '0 : mask_q) | wr_en;
    value_d       = frame_done ? stg_val_q : value_q;
    digit_ok_d    = frame_done ? stg_ok_q  : digit_ok_q;
    frame_valid_d = frame_done;
    frame_err_d   = frame_done && !(&stg_ok_q);
    bus_err_d     = bus_err_q || bus_err_set;
  end

  assign value       = value_q;
  assign digit_ok    = digit_ok_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench: drives dwell segments on the scan bus and compares emitted
// frames against a segment-level model of which dwells should be captured.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [15:0]   value;
  logic [3:0]    digit_ok;
  logic          frame_valid, frame_err, bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  ok;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  frame_t mon_f;

  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0] m_val [4];
  logic       m_okb [4];
  logic [3:0] m_mask;
  logic       m_bus_err;
  logic       m_prev_legal;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .value       (value),
    .digit_ok    (digit_ok),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && frame_valid === 1'b1) begin
      mon_f.v   = value;
      mon_f.ok  = digit_ok;
      mon_f.err = frame_err;
      obs_q.push_back(mon_f);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 4'h0;
      m_okb[i] = 1'b0;
    end
    m_mask       = 4'h0;
    m_bus_err    = 1'b0;
    m_prev_legal = 1'b0;
  endtask

  // A legal dwell of >=20 cycles is always captured; <=15 never is.
  task automatic model_step(input logic [3:0] an, input logic [6:0] seg, input int n);
    int         zeros = 0;
    int         k = 0;
    logic [3:0] nib = 4'h0;
    logic       ok = 1'b0;
    frame_t     f;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) begin
        zeros++;
        k = i;
      end
    end
    if (zeros > 1 && m_prev_legal) m_bus_err = 1'b1;
    if (zeros == 1 && n >= 20) begin
      for (int j = 0; j < 16; j++) begin
        if (glyphs[j] == seg) begin
          nib = 4'(j);
          ok  = 1'b1;
        end
      end
      m_val[k]  = nib;
      m_okb[k]  = ok;
      m_mask[k] = 1'b1;
      if (m_mask == 4'hF) begin
        f.v   = {m_val[3], m_val[2], m_val[1], m_val[0]};
        f.ok  = {m_okb[3], m_okb[2], m_okb[1], m_okb[0]};
        f.err = !(m_okb[0] && m_okb[1] && m_okb[2] && m_okb[3]);
        exp_q.push_back(f);
        m_mask = 4'h0;
      end
    end
    m_prev_legal = (zeros == 1);
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    model_step(an, seg, n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (value !== 16'h0)    begin errors++; $display("FAIL reset value: got %h expected 0000", value); end
    checks++; if (digit_ok !== 4'h0)  begin errors++; $display("FAIL reset digit_ok: got %b expected 0000", digit_ok); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset frame_valid: got %b expected 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
    checks++; if (bus_err !== 1'b0)   begin errors++; $display("FAIL reset bus_err: got %b expected 0", bus_err); end
    $display("reset value=%h digit_ok=%b bus_err=%b", value, digit_ok, bus_err);
  endtask

  task automatic test_glyph_sweep();
    frame_t o, e;
    for (int g = 0; g < 16; g++) begin
      show(4'b1110, glyphs[g], 20);
      show(4'b1101, 7'h40, 20);
      show(4'b1011, 7'h40, 20);
      show(4'b0111, 7'h40, 20);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sweep frame_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.v !== e.v || o.ok !== e.ok || o.err !== e.err) begin
        errors++; $display("FAIL sweep frame: got v=%h ok=%b err=%b expected v=%h ok=%b err=%b", o.v, o.ok, o.err, e.v, e.ok, e.err);
      end else $display("sweep frame v=%h ok=%b err=%b", o.v, o.ok, o.err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_scan_frame();
    frame_t o, e;
    show(4'b0111, 7'h79, 20);
    show(4'b1011, 7'h08, 20);
    show(4'b1101, 7'h24, 20);
    show(4'b1110, 7'h03, 20);
    checks++; if (value !== 16'h1A2B) begin errors++; $display("FAIL scan value: got %h expected 1a2b", value); end
    checks++; if (digit_ok !== 4'hF)  begin errors++; $display("FAIL scan digit_ok: got %b expected 1111", digit_ok); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL scan frame_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.v !== e.v || o.ok !== e.ok || o.err !== e.err) begin
        errors++; $display("FAIL scan frame: got v=%h ok=%b err=%b expected v=%h ok=%b err=%b", o.v, o.ok, o.err, e.v, e.ok, e.err);
      end else $display("scan frame v=%h ok=%b err=%b", o.v, o.ok, o.err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    frame_t o, e;
    show(4'b1011, 7'h30, 15);
    show(4'b1011, 7'h19, 20);
    show(4'b1110, 7'h79, 20);
    show(4'b1101, 7'h24, 20);
    show(4'b0111, 7'h12, 20);
    checks++; if (value[11:8] !== 4'h4) begin errors++; $display("FAIL glitch digit2: got %h expected 4", value[11:8]); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL glitch frame_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.v !== e.v || o.ok !== e.ok || o.err !== e.err) begin
        errors++; $display("FAIL glitch frame: got v=%h ok=%b err=%b expected v=%h ok=%b err=%b", o.v, o.ok, o.err, e.v, e.ok, e.err);
      end else $display("glitch frame v=%h ok=%b err=%b", o.v, o.ok, o.err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_blank_and_bus_err();
    frame_t o, e;
    show(4'b1110, 7'h40, 20);
    show(4'b1101, 7'h7F, 20);
    show(4'b1011, 7'h40, 20);
    show(4'b0111, 7'h40, 20);
    checks++; if (digit_ok !== 4'b1101) begin errors++; $display("FAIL blank digit_ok: got %b expected 1101", digit_ok); end
    checks++; if (value[7:4] !== 4'h0)  begin errors++; $display("FAIL blank digit1: got %h expected 0", value[7:4]); end
    checks++; if (bus_err !== 1'b0)     begin errors++; $display("FAIL blank bus_err_early: got %b expected 0", bus_err); end
    show(4'b0011, 7'h40, 5);
    checks++; if (bus_err !== m_bus_err) begin errors++; $display("FAIL bus_err set: got %b expected %b", bus_err, m_bus_err); end
    show(4'b1110, 7'h06, 20);
    show(4'b1101, 7'h21, 20);
    show(4'b1011, 7'h46, 20);
    show(4'b0111, 7'h03, 20);
    checks++; if (bus_err !== m_bus_err) begin errors++; $display("FAIL bus_err sticky: got %b expected %b", bus_err, m_bus_err); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL blank frame_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.v !== e.v || o.ok !== e.ok || o.err !== e.err) begin
        errors++; $display("FAIL blank frame: got v=%h ok=%b err=%b expected v=%h ok=%b err=%b", o.v, o.ok, o.err, e.v, e.ok, e.err);
      end else $display("blank frame v=%h ok=%b err=%b", o.v, o.ok, o.err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_long_dwell();
    frame_t o, e;
    int     n;
    show(4'hF, 7'h7F, 3);
    an_n  = 4'b1110;
    seg_n = 7'h12;
    repeat (1000) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL dwell early_frame: got %0d expected 0", obs_q.size());
    end
    model_step(4'b1110, 7'h12, 1000);
    show(4'b1101, 7'h18, 20);
    show(4'b1011, 7'h78, 20);
    show(4'hF, 7'h7F, 3);
    an_n  = 4'b0111;
    seg_n = 7'h46;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      #1;
      if (frame_valid === 1'b1) break;
    end
    checks++;
    if (n != SC + 3) begin
      errors++; $display("FAIL dwell latency: got %0d edges expected %0d", n, SC + 3);
    end
    @(negedge clk);
    model_step(4'b0111, 7'h46, 20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL dwell frame_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.v !== e.v || o.ok !== e.ok || o.err !== e.err) begin
        errors++; $display("FAIL dwell frame: got v=%h ok=%b err=%b expected v=%h ok=%b err=%b", o.v, o.ok, o.err, e.v, e.ok, e.err);
      end else $display("dwell frame v=%h ok=%b err=%b latency=%0d", o.v, o.ok, o.err, n);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    frame_t o, e;
    show(4'b1110, 7'h02, 20);
    show(4'b1101, 7'h00, 20);
    show(4'b1011, 7'h0E, 20);
    show(4'b0111, 7'h21, 8);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (value !== 16'h0)    begin errors++; $display("FAIL midreset value: got %h expected 0000", value); end
    checks++; if (digit_ok !== 4'h0)  begin errors++; $display("FAIL midreset digit_ok: got %b expected 0000", digit_ok); end
    checks++; if (bus_err !== 1'b0)   begin errors++; $display("FAIL midreset bus_err: got %b expected 0", bus_err); end
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL midreset early_frame: got %0d expected 0", obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
    show(4'hF, 7'h7F, 3);
    show(4'b0111, 7'h21, 20);
    checks++; if (frame_valid !== 1'b0 || value !== 16'h0) begin
      errors++; $display("FAIL midreset partial: got fv=%b value=%h expected fv=0 value=0000", frame_valid, value);
    end
    show(4'b1110, 7'h02, 20);
    show(4'b1101, 7'h00, 20);
    show(4'b1011, 7'h0E, 20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midreset frame_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.v !== e.v || o.ok !== e.ok || o.err !== e.err) begin
        errors++; $display("FAIL midreset frame: got v=%h ok=%b err=%b expected v=%h ok=%b err=%b", o.v, o.ok, o.err, e.v, e.ok, e.err);
      end else $display("midreset frame v=%h ok=%b err=%b", o.v, o.ok, o.err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_scan();
    frame_t     o, e;
    logic [3:0] an, p_an;
    logic [6:0] seg, p_seg;
    int         n;
    p_an  = an_n;
    p_seg = seg_n;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 99) < 12) an = 4'hF;
      else                             an = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 85) seg = glyphs[$urandom_range(0, 15)];
      else                             seg = 7'($urandom);
      if ($urandom_range(0, 99) < 70) n = $urandom_range(20, 28);
      else                             n = $urandom_range(3, 15);
      if (an == p_an && seg == p_seg) seg = seg ^ 7'h01;
      show(an, seg, n);
      p_an  = an;
      p_seg = seg;
    end
    checks++; if (bus_err !== m_bus_err) begin errors++; $display("FAIL random bus_err: got %b expected %b", bus_err, m_bus_err); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random frame_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.v !== e.v || o.ok !== e.ok || o.err !== e.err) begin
        errors++; $display("FAIL random frame: got v=%h ok=%b err=%b expected v=%h ok=%b err=%b", o.v, o.ok, o.err, e.v, e.ok, e.err);
      end else $display("random frame v=%h ok=%b err=%b", o.v, o.ok, o.err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    @(negedge clk);
    test_reset();
    test_glyph_sweep();
    test_scan_frame();
    test_glitch();
    test_blank_and_bus_err();
    test_long_dwell();
    test_reset_mid_frame();
    test_random_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
